// File: rtl/execute_mdu_if.sv
// Execute-stage bundle: E-stage instruction fields in, M-stage pipeline register out.
// Latency: none, signal grouping only.
// Backpressure: busy_o goes back to the hazard unit, which then holds the E instruction.
interface execute_mdu_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    // E-stage controls
    logic              reg_write_e_i;
    logic              mem_write_e_i;
    logic              mem_to_reg_e_i;
    logic              reg_dst_e_i;
    logic              link_e_i;
    logic [1:0]        alu_src_e_i;
    logic [3:0]        alu_control_e_i;
    logic [2:0]        md_op_e_i;
    // E-stage operands and register fields
    logic [DATA_W-1:0] reg_data_1_e_i;
    logic [DATA_W-1:0] reg_data_2_e_i;
    logic [DATA_W-1:0] sign_imm_e_i;
    logic [DATA_W-1:0] result_w_i;
    logic [REG_AW-1:0] rt_e_i;
    logic [REG_AW-1:0] rd_e_i;
    logic [4:0]        shamt_e_i;
    logic [1:0]        forward_a_e_i;
    logic [1:0]        forward_b_e_i;
    logic              flush_e_i;
    // Stage outputs
    logic [REG_AW-1:0] write_reg_e_o;
    logic              busy_o;
    logic              div_zero_o;
    logic              reg_write_m_o;
    logic              mem_write_m_o;
    logic              mem_to_reg_m_o;
    logic [DATA_W-1:0] alu_out_m_o;
    logic [DATA_W-1:0] write_data_m_o;
    logic [REG_AW-1:0] write_reg_m_o;

    modport slave (
        input  reg_write_e_i, mem_write_e_i, mem_to_reg_e_i, reg_dst_e_i, link_e_i,
        input  alu_src_e_i, alu_control_e_i, md_op_e_i,
        input  reg_data_1_e_i, reg_data_2_e_i, sign_imm_e_i, result_w_i,
        input  rt_e_i, rd_e_i, shamt_e_i, forward_a_e_i, forward_b_e_i, flush_e_i,
        output write_reg_e_o, busy_o, div_zero_o,
        output reg_write_m_o, mem_write_m_o, mem_to_reg_m_o,
        output alu_out_m_o, write_data_m_o, write_reg_m_o
    );

    modport master (
        output reg_write_e_i, mem_write_e_i, mem_to_reg_e_i, reg_dst_e_i, link_e_i,
        output alu_src_e_i, alu_control_e_i, md_op_e_i,
        output reg_data_1_e_i, reg_data_2_e_i, sign_imm_e_i, result_w_i,
        output rt_e_i, rd_e_i, shamt_e_i, forward_a_e_i, forward_b_e_i, flush_e_i,
        input  write_reg_e_o, busy_o, div_zero_o,
        input  reg_write_m_o, mem_write_m_o, mem_to_reg_m_o,
        input  alu_out_m_o, write_data_m_o, write_reg_m_o
    );
endinterface

// File: rtl/execute_mdu.sv
// Execute stage: forwarding, ALU, iterative mult/div unit with HI/LO, E->M pipeline register.
// Latency: ALU result in M one cycle later; HI/LO updated DATA_W cycles after an MDU start.
// Backpressure: busy_o stalls an MDU instruction while the unit runs; M loads bubbles meanwhile.
// Optional divider: define EXECUTE_MDU_DIV_EN to build div/divu support.
module execute_mdu #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    execute_mdu_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_MFHI  = 3'd5;
    localparam logic [2:0] MD_MFLO  = 3'd6;
`ifdef EXECUTE_MDU_DIV_EN
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
`endif

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_LUI  = 4'b1011;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t              r_state, w_state_nxt;
    logic                w_done;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_hi, r_lo;
    logic [2*DATA_W-1:0] r_acc;      // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [DATA_W-1:0]   r_opd;      // multiplicand or divisor magnitude
    logic                r_neg;      // negate product / quotient at completion

    logic [DATA_W-1:0]   w_fwd_a, w_fwd_b, w_src_a, w_src_b, w_alu_out, w_result_e;
    logic [REG_AW-1:0]   w_write_reg_e;
    logic                w_is_mul, w_is_div, w_md_used, w_busy, w_bubble;
    logic                w_start_mul, w_start_div, w_signed, w_a_neg, w_b_neg;
    logic [DATA_W-1:0]   w_mag_a, w_mag_b;
    logic [DATA_W:0]     w_mul_sum;
    logic [2*DATA_W-1:0] w_mul_acc, w_mul_res;

    logic                r_reg_write_m, r_mem_write_m, r_mem_to_reg_m;
    logic [DATA_W-1:0]   r_alu_out_m, r_write_data_m;
    logic [REG_AW-1:0]   r_write_reg_m;

`ifdef EXECUTE_MDU_DIV_EN
    logic                r_neg_rem, r_dz, r_div_zero;
    logic [DATA_W-1:0]   r_dividend;
    logic [DATA_W:0]     w_rem_sh, w_diff;
    logic                w_q_bit;
    logic [2*DATA_W-1:0] w_div_acc;
    logic [DATA_W-1:0]   w_quo, w_rem, w_div_hi, w_div_lo;
`endif

    // Forwarding: 01 takes the W-stage result, 10 the M-stage ALU output, anything else the register file
    assign w_fwd_a = (bus.forward_a_e_i == 2'b01) ? bus.result_w_i :
                     (bus.forward_a_e_i == 2'b10) ? r_alu_out_m : bus.reg_data_1_e_i;
    assign w_fwd_b = (bus.forward_b_e_i == 2'b01) ? bus.result_w_i :
                     (bus.forward_b_e_i == 2'b10) ? r_alu_out_m : bus.reg_data_2_e_i;

    assign w_src_a = bus.alu_src_e_i[1] ? {{(DATA_W-5){1'b0}}, bus.shamt_e_i} : w_fwd_a;
    assign w_src_b = bus.alu_src_e_i[0] ? bus.sign_imm_e_i : w_fwd_b;

    assign w_write_reg_e = bus.link_e_i    ? {REG_AW{1'b1}} :
                           bus.reg_dst_e_i ? bus.rd_e_i : bus.rt_e_i;

    // ALU; shifts take the amount from src A and shift src B
    always_comb begin
        w_alu_out = '0;
        case (bus.alu_control_e_i)
            ALU_AND:  w_alu_out = w_src_a & w_src_b;
            ALU_OR:   w_alu_out = w_src_a | w_src_b;
            ALU_ADD:  w_alu_out = w_src_a + w_src_b;
            ALU_XOR:  w_alu_out = w_src_a ^ w_src_b;
            ALU_NOR:  w_alu_out = ~(w_src_a | w_src_b);
            ALU_SLTU: w_alu_out = {{(DATA_W-1){1'b0}}, (w_src_a < w_src_b)};
            ALU_SUB:  w_alu_out = w_src_a - w_src_b;
            ALU_SLT:  w_alu_out = {{(DATA_W-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
            ALU_SLL:  w_alu_out = w_src_b << w_src_a[4:0];
            ALU_SRL:  w_alu_out = w_src_b >> w_src_a[4:0];
            ALU_SRA:  w_alu_out = $unsigned($signed(w_src_b) >>> w_src_a[4:0]);
            ALU_LUI:  w_alu_out = {w_src_b[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
            default:  w_alu_out = '0;
        endcase
    end

    assign w_result_e = (bus.md_op_e_i == MD_MFHI) ? r_hi :
                        (bus.md_op_e_i == MD_MFLO) ? r_lo : w_alu_out;

    // MDU op decode; without the divider, div/divu decode as no operation
    assign w_is_mul = (bus.md_op_e_i == MD_MULT) || (bus.md_op_e_i == MD_MULTU);
`ifdef EXECUTE_MDU_DIV_EN
    assign w_is_div = (bus.md_op_e_i == MD_DIV) || (bus.md_op_e_i == MD_DIVU);
    assign w_signed = (bus.md_op_e_i == MD_MULT) || (bus.md_op_e_i == MD_DIV);
`else
    assign w_is_div = 1'b0;
    assign w_signed = (bus.md_op_e_i == MD_MULT);
`endif
    assign w_md_used   = w_is_mul || w_is_div ||
                         (bus.md_op_e_i == MD_MFHI) || (bus.md_op_e_i == MD_MFLO);
    assign w_busy      = (r_state != IDLE) && w_md_used;
    assign w_bubble    = w_busy || bus.flush_e_i;
    assign w_start_mul = (r_state == IDLE) && w_is_mul && !bus.flush_e_i && !w_busy;
    assign w_start_div = (r_state == IDLE) && w_is_div && !bus.flush_e_i && !w_busy;

    // Operands run through the unit as magnitudes; signs are re-applied on completion
    assign w_a_neg = w_signed && w_fwd_a[DATA_W-1];
    assign w_b_neg = w_signed && w_fwd_b[DATA_W-1];
    assign w_mag_a = w_a_neg ? ({DATA_W{1'b0}} - w_fwd_a) : w_fwd_a;
    assign w_mag_b = w_b_neg ? ({DATA_W{1'b0}} - w_fwd_b) : w_fwd_b;

    // Shift-add multiply step: add multiplicand when the low multiplier bit is set, then shift right
    assign w_mul_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]} +
                       (r_acc[0] ? {1'b0, r_opd} : {(DATA_W+1){1'b0}});
    assign w_mul_acc = {w_mul_sum, r_acc[DATA_W-1:1]};
    assign w_mul_res = r_neg ? ({(2*DATA_W){1'b0}} - w_mul_acc) : w_mul_acc;

`ifdef EXECUTE_MDU_DIV_EN
    // Restoring divide step: shift in the next dividend bit, subtract divisor if it fits
    assign w_rem_sh  = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_opd};
    assign w_q_bit   = ~w_diff[DATA_W];
    assign w_div_acc = {(w_q_bit ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0]),
                        r_acc[DATA_W-2:0], w_q_bit};
    assign w_quo     = w_div_acc[DATA_W-1:0];
    assign w_rem     = w_div_acc[2*DATA_W-1:DATA_W];
    // Zero divisor: HI keeps the dividend, LO saturates to all ones
    assign w_div_lo  = r_dz ? {DATA_W{1'b1}} : (r_neg ? ({DATA_W{1'b0}} - w_quo) : w_quo);
    assign w_div_hi  = r_dz ? r_dividend : (r_neg_rem ? ({DATA_W{1'b0}} - w_rem) : w_rem);
`endif

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state; the last iteration runs when the counter reaches zero
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_mul)      w_state_nxt = MUL;
                else if (w_start_div) w_state_nxt = DIV;
            end
            MUL, DIV: begin
                if (r_cnt == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // MDU datapath: operand capture on start, one bit per cycle, HI/LO write on completion
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opd      <= '0;
            r_neg      <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
`ifdef EXECUTE_MDU_DIV_EN
            r_neg_rem  <= 1'b0;
            r_dz       <= 1'b0;
            r_dividend <= '0;
            r_div_zero <= 1'b0;
`endif
        end else begin
`ifdef EXECUTE_MDU_DIV_EN
            r_div_zero <= 1'b0;
`endif
            if (w_start_mul || w_start_div) begin
                r_cnt <= CNT_W'(DATA_W - 1);
                r_acc <= {{DATA_W{1'b0}}, w_mag_a};
                r_opd <= w_mag_b;
                r_neg <= w_a_neg ^ w_b_neg;
`ifdef EXECUTE_MDU_DIV_EN
                r_neg_rem  <= w_a_neg;
                r_dz       <= (w_fwd_b == '0);
                r_dividend <= w_fwd_a;
`endif
            end else if (r_state == MUL) begin
                r_acc <= w_mul_acc;
                r_cnt <= w_done ? '0 : (r_cnt - CNT_W'(1));
                if (w_done) begin
                    r_hi <= w_mul_res[2*DATA_W-1:DATA_W];
                    r_lo <= w_mul_res[DATA_W-1:0];
                end
`ifdef EXECUTE_MDU_DIV_EN
            end else if (r_state == DIV) begin
                r_acc <= w_div_acc;
                r_cnt <= w_done ? '0 : (r_cnt - CNT_W'(1));
                if (w_done) begin
                    r_hi       <= w_div_hi;
                    r_lo       <= w_div_lo;
                    r_div_zero <= r_dz;
                end
`endif
            end
        end
    end

    // E->M register: bubble on stall or flush, otherwise capture the E instruction
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_mem_to_reg_m <= 1'b0;
            r_alu_out_m    <= '0;
            r_write_data_m <= '0;
            r_write_reg_m  <= '0;
        end else if (w_bubble) begin
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_mem_to_reg_m <= 1'b0;
            r_alu_out_m    <= '0;
            r_write_data_m <= '0;
            r_write_reg_m  <= '0;
        end else begin
            r_reg_write_m  <= bus.reg_write_e_i;
            r_mem_write_m  <= bus.mem_write_e_i;
            r_mem_to_reg_m <= bus.mem_to_reg_e_i;
            r_alu_out_m    <= w_result_e;
            r_write_data_m <= w_fwd_b;
            r_write_reg_m  <= w_write_reg_e;
        end
    end

    assign bus.write_reg_e_o  = w_write_reg_e;
    assign bus.busy_o         = w_busy;
`ifdef EXECUTE_MDU_DIV_EN
    assign bus.div_zero_o     = r_div_zero;
`else
    assign bus.div_zero_o     = 1'b0;
`endif
    assign bus.reg_write_m_o  = r_reg_write_m;
    assign bus.mem_write_m_o  = r_mem_write_m;
    assign bus.mem_to_reg_m_o = r_mem_to_reg_m;
    assign bus.alu_out_m_o    = r_alu_out_m;
    assign bus.write_data_m_o = r_write_data_m;
    assign bus.write_reg_m_o  = r_write_reg_m;
endmodule

// File: tb/tb_execute_mdu.sv
// Testbench for execute_mdu: directed steps, M-stage results checked against a scoreboard queue.
// Inputs driven and outputs sampled on the falling clock edge.
// Divider expectations follow EXECUTE_MDU_DIV_EN.
module tb_execute_mdu;
    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MFHI  = 3'd5;
    localparam logic [2:0] MD_MFLO  = 3'd6;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b1000;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [DW-1:0] sb_alu[$];
    string         sb_tag[$];

    execute_mdu_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

    execute_mdu #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] md, input logic [3:0] aluc, input logic [1:0] src,
                         input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] imm,
                         input logic [1:0] fa, input logic [1:0] fb, input logic rw);
        bus.md_op_e_i       = md;
        bus.alu_control_e_i = aluc;
        bus.alu_src_e_i     = src;
        bus.reg_data_1_e_i  = a;
        bus.reg_data_2_e_i  = b;
        bus.sign_imm_e_i    = imm;
        bus.forward_a_e_i   = fa;
        bus.forward_b_e_i   = fb;
        bus.reg_write_e_i   = rw;
        bus.mem_write_e_i   = 1'b0;
        bus.mem_to_reg_e_i  = 1'b0;
        bus.reg_dst_e_i     = 1'b1;
        bus.link_e_i        = 1'b0;
        bus.rt_e_i          = 5'd8;
        bus.rd_e_i          = 5'd9;
        bus.shamt_e_i       = 5'd0;
        bus.result_w_i      = '0;
        bus.flush_e_i       = 1'b0;
    endtask

    task automatic nop();
        issue(MD_NONE, ALU_ADD, 2'b00, '0, '0, '0, 2'b00, 2'b00, 1'b0);
    endtask

    task automatic expect_m(input string tag, input logic [DW-1:0] val);
        sb_alu.push_back(val);
        sb_tag.push_back(tag);
    endtask

    task automatic check_m();
        logic [DW-1:0] e;
        string         t;
        chk("sb_nonempty", 64'(sb_alu.size() != 0), 64'd1);
        if (sb_alu.size() != 0) begin
            e = sb_alu.pop_front();
            t = sb_tag.pop_front();
            chk(t, 64'(bus.alu_out_m_o), 64'(e));
        end
    endtask

    // Start an MDU op, then run nops until well past completion, counting div_zero pulses
    task automatic run_md(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output int dz_cnt);
        issue(op, ALU_ADD, 2'b00, a, b, '0, 2'b00, 2'b00, 1'b0);
        tick();
        nop();
        dz_cnt = 0;
        for (int i = 0; i < DW + 1; i++) begin
            tick();
            if (bus.div_zero_o === 1'b1) dz_cnt++;
        end
    endtask

    task automatic read_hilo(input string tag, input logic [DW-1:0] exp_hi, input logic [DW-1:0] exp_lo);
        issue(MD_MFHI, ALU_ADD, 2'b00, '0, '0, '0, 2'b00, 2'b00, 1'b1);
        expect_m({tag, "_hi"}, exp_hi);
        tick();
        check_m();
        issue(MD_MFLO, ALU_ADD, 2'b00, '0, '0, '0, 2'b00, 2'b00, 1'b1);
        expect_m({tag, "_lo"}, exp_lo);
        tick();
        check_m();
    endtask

    initial begin
        int dz;
        int busy_cnt;
        int bub_bad;
        logic [2:0] mid_op;

        // Reset state
        nop();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_alu_out_m",    64'(bus.alu_out_m_o),    64'd0);
        chk("rst_write_data_m", 64'(bus.write_data_m_o), 64'd0);
        chk("rst_write_reg_m",  64'(bus.write_reg_m_o),  64'd0);
        chk("rst_reg_write_m",  64'(bus.reg_write_m_o),  64'd0);
        chk("rst_busy",         64'(bus.busy_o),         64'd0);
        chk("rst_div_zero",     64'(bus.div_zero_o),     64'd0);
        rst_n = 1'b1;

        // Destination register select
        issue(MD_NONE, ALU_ADD, 2'b00, '0, '0, '0, 2'b00, 2'b00, 1'b1);
        bus.link_e_i = 1'b1;
        #1 chk("wreg_link", 64'(bus.write_reg_e_o), 64'd31);
        bus.link_e_i = 1'b0;
        #1 chk("wreg_rd", 64'(bus.write_reg_e_o), 64'd9);
        bus.reg_dst_e_i = 1'b0;
        #1 chk("wreg_rt", 64'(bus.write_reg_e_o), 64'd8);

        // addi 0x10 then addi 4 forwarding the M-stage result into A
        issue(MD_NONE, ALU_ADD, 2'b01, 32'h10, '0, '0, 2'b00, 2'b00, 1'b1);
        expect_m("addi_base", 32'h10);
        tick();
        check_m();
        chk("m_wreg_rd",  64'(bus.write_reg_m_o), 64'd9);
        chk("m_regwrite", 64'(bus.reg_write_m_o), 64'd1);
        issue(MD_NONE, ALU_ADD, 2'b01, '0, 32'h55, 32'h4, 2'b10, 2'b01, 1'b1);
        bus.result_w_i = 32'hCAFE_0001;
        expect_m("addi_fwd_m", 32'h14);
        tick();
        check_m();
        chk("wdata_fwd_w", 64'(bus.write_data_m_o), 64'hCAFE_0001);

        // forward code 11 selects the register file
        issue(MD_NONE, ALU_OR, 2'b00, 32'hF0, 32'h0F, '0, 2'b11, 2'b11, 1'b1);
        bus.result_w_i = 32'h1234_5678;
        expect_m("or_fwd11", 32'hFF);
        tick();
        check_m();
        chk("wdata_fwd11", 64'(bus.write_data_m_o), 64'h0F);

        // sll with shamt as src A
        issue(MD_NONE, ALU_SLL, 2'b10, 32'hFFFF, 32'h3, '0, 2'b00, 2'b00, 1'b1);
        bus.shamt_e_i = 5'd4;
        expect_m("sll_shamt", 32'h30);
        tick();
        check_m();

        // flush gives a bubble
        issue(MD_NONE, ALU_ADD, 2'b01, 32'h5, '0, 32'h1, 2'b00, 2'b00, 1'b1);
        bus.mem_write_e_i = 1'b1;
        bus.flush_e_i     = 1'b1;
        tick();
        chk("flush_alu_out", 64'(bus.alu_out_m_o),   64'd0);
        chk("flush_regw",    64'(bus.reg_write_m_o), 64'd0);
        chk("flush_memw",    64'(bus.mem_write_m_o), 64'd0);

        // signed mult, mflo waiting behind it
        issue(MD_MULT, ALU_ADD, 2'b00, 32'hFFFF_FFFF, 32'h2, '0, 2'b00, 2'b00, 1'b0);
        tick();
        nop();
        tick();
        issue(MD_MFLO, ALU_ADD, 2'b00, '0, '0, '0, 2'b00, 2'b00, 1'b1);
        #1;
        busy_cnt = 0;
        bub_bad  = 0;
        while (bus.busy_o === 1'b1 && busy_cnt < 100) begin
            busy_cnt++;
            tick();
            if (bus.alu_out_m_o !== '0 || bus.reg_write_m_o !== 1'b0) bub_bad++;
        end
        chk("busy_cycles",  64'(busy_cnt), 64'd31);
        chk("busy_bubbles", 64'(bub_bad),  64'd0);
        expect_m("mult_lo_first", 32'hFFFF_FFFE);
        tick();
        check_m();
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // unsigned mult
        run_md(MD_MULTU, 32'hFFFF_FFFF, 32'h2, dz);
        chk("multu_no_dz", 64'(dz), 64'd0);
        read_hilo("multu", 32'h1, 32'hFFFF_FFFE);

        // flushed mult must not start
        issue(MD_MULT, ALU_ADD, 2'b00, 32'h3, 32'h3, '0, 2'b00, 2'b00, 1'b0);
        bus.flush_e_i = 1'b1;
        tick();
        issue(MD_MFLO, ALU_ADD, 2'b00, '0, '0, '0, 2'b00, 2'b00, 1'b1);
        #1 chk("flush_no_start_busy", 64'(bus.busy_o), 64'd0);
        expect_m("flush_no_start_lo", 32'hFFFF_FFFE);
        tick();
        check_m();

`ifdef EXECUTE_MDU_DIV_EN
        run_md(MD_DIV, 32'hFFFF_FFF9, 32'h2, dz);
        chk("div_s_no_dz", 64'(dz), 64'd0);
        read_hilo("div_s", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md(MD_DIV, 32'h7, 32'hFFFF_FFFE, dz);
        read_hilo("div_negdivisor", 32'h1, 32'hFFFF_FFFD);
        run_md(MD_DIVU, 32'h7, 32'h2, dz);
        read_hilo("divu", 32'h1, 32'h3);
        run_md(MD_DIV, 32'h5, 32'h0, dz);
        chk("div0_pulse_count", 64'(dz), 64'd1);
        read_hilo("div0", 32'h5, 32'hFFFF_FFFF);
        mid_op = MD_DIV;
`else
        run_md(MD_DIV, 32'h5, 32'h0, dz);
        chk("div0_off_no_pulse", 64'(dz), 64'd0);
        read_hilo("div0_off", 32'h1, 32'hFFFF_FFFE);
        run_md(MD_DIVU, 32'h7, 32'h2, dz);
        read_hilo("divu_off", 32'h1, 32'hFFFF_FFFE);
        mid_op = MD_MULT;
`endif

        // reset in the middle of an operation
        issue(mid_op, ALU_ADD, 2'b00, 32'd100, 32'd7, '0, 2'b00, 2'b00, 1'b0);
        tick();
        nop();
        for (int i = 0; i < 9; i++) tick();
        issue(MD_MFLO, ALU_ADD, 2'b00, '0, '0, '0, 2'b00, 2'b00, 1'b1);
        #1 chk("mid_busy_before_rst", 64'(bus.busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  64'(bus.busy_o),      64'd0);
        chk("mid_rst_m",     64'(bus.alu_out_m_o), 64'd0);
        chk("mid_rst_dz",    64'(bus.div_zero_o),  64'd0);
        tick();
        rst_n = 1'b1;
        #1 chk("post_rst_busy", 64'(bus.busy_o), 64'd0);
        expect_m("post_rst_lo", 32'h0);
        tick();
        check_m();
        read_hilo("post_rst", 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
